// File: rtl/composer_pkg.sv
// rtl/composer_pkg.sv - shared widths, rest code and player state encoding
package composer_pkg;

    localparam int ADDR_W = 5;
    localparam int NOTE_W = 8;
    localparam logic [7:0] REST = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } player_state_e;

endpackage

// File: rtl/song_player_if.sv
// rtl/song_player_if.sv - note-memory read bus between player and recorder memory
interface song_player_if #(
    parameter int ADDR_W = composer_pkg::ADDR_W,
    parameter int NOTE_W = composer_pkg::NOTE_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [NOTE_W-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rd_data
    );

endinterface

// File: rtl/duration_timer.sv
// rtl/duration_timer.sv - loadable down-counter that holds at zero
module duration_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/song_player.sv
// rtl/song_player.sv - replays recorded note codes with fixed note and gap durations
module song_player #(
    parameter int ADDR_W      = composer_pkg::ADDR_W,
    parameter int NOTE_W      = composer_pkg::NOTE_W,
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic [ADDR_W:0]   song_length,
    song_player_if.master     mem,
    output logic [NOTE_W-1:0] note_code,
    output logic              note_valid,
    output logic              busy,
    output logic              play_done
);

    import composer_pkg::*;

    localparam int MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] NOTE_LOAD = TW'(NOTE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    player_state_e     state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_zero;
    logic              last_note;

    duration_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign last_note = ({1'b0, index_q} == (len_q - (ADDR_W+1)'(1)));

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        len_d    = len_q;
        note_d   = note_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (play_start) begin
                    if (song_length != '0) begin
                        state_d = ST_FETCH;
                        index_d = '0;
                        len_d   = (song_length > MAX_LEN) ? MAX_LEN : song_length;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                note_d   = mem.mem_rd_data;
                tmr_load = 1'b1;
                tmr_val  = NOTE_LOAD;
                state_d  = ST_PLAY;
            end
            ST_PLAY, ST_GAP: begin
                if (tmr_zero) begin
                    if (state_q == ST_PLAY && GAP_CYCLES > 0) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = ST_GAP;
                    end else if (last_note) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Stop wins over everything, including a start seen in the same cycle.
        if (play_stop) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            len_q   <= '0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            note_q  <= note_d;
        end
    end

    assign mem.mem_addr  = index_q;
    assign mem.mem_rd_en = (state_q == ST_FETCH);
    assign note_code     = note_q;
    assign note_valid    = (state_q == ST_PLAY) && (note_q != REST);
    assign busy          = (state_q != ST_IDLE);
    assign play_done     = (state_q == ST_DONE);

endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameter ADDR_W, 5, note-memory address width (32 recorded notes max).
REQ-002 Parameter NOTE_W, 8, width of one stored note code (PS/2 key code as recorded).
REQ-003 Parameter NOTE_CYCLES, 12500000, clocks each note sounds (0.25 s at 50 MHz); legal range >= 1.
REQ-004 Parameter GAP_CYCLES, 1250000, silent clocks between notes; 0 is legal.
REQ-005 clock  input  1  single clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 play_start  input  1  one-cycle request to play the whole recorded song.
REQ-008 play_stop  input  1  abort playback.
REQ-009 song_length  input  ADDR_W+1  number of recorded notes, sampled at accepted start.
REQ-010 mem_addr  output  ADDR_W  read address into the recorder's note memory.
REQ-011 mem_rd_en  output  1  read strobe; memory is synchronous, data valid the cycle after.
REQ-012 mem_rd_data  input  NOTE_W  note code returned by memory.
REQ-013 note_code  output  NOTE_W  note currently driven to the tone generator.
REQ-014 note_valid  output  1  high while note_code is to sound.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 play_done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 States: IDLE, FETCH, WAIT_DATA, PLAY, GAP, DONE; mem_rd_en=1 only in FETCH; mem_addr=index register in all states.
REQ-018 IDLE: play_start=1 and song_length!=0 -> FETCH, index=0, length latched; play_start=1 and song_length==0 -> DONE.
REQ-019 FETCH -> WAIT_DATA unconditionally (one cycle).
REQ-020 WAIT_DATA: note_code <= mem_rd_data; timer loaded NOTE_CYCLES-1; -> PLAY.
REQ-021 PLAY: note_valid=1 unless note_code==REST (8'h00), which plays silence for the same duration; timer==0 -> GAP if GAP_CYCLES>0, else evaluate end-of-song directly.
REQ-022 GAP: note_valid=0, lasts exactly GAP_CYCLES cycles.
REQ-023 End-of-song: index==latched_length-1 -> DONE; else index+1 -> FETCH.
REQ-024 DONE: play_done=1 for exactly one cycle -> IDLE.
REQ-025 Timing: start accepted at edge k -> FETCH in cycle k+1, note_valid first high in cycle k+3; per-note period = 2+NOTE_CYCLES+GAP_CYCLES cycles.
REQ-026 play_start while busy is ignored; song_length changes after acceptance have no effect.
REQ-027 play_stop=1 in any non-IDLE state -> IDLE next cycle, note_valid=0, no play_done; play_stop has priority over play_start in IDLE.
REQ-028 Index never exceeds 2^ADDR_W-1; song_length > 2^ADDR_W is clamped to 2^ADDR_W.
REQ-029 Timer width = clog2(max(NOTE_CYCLES,GAP_CYCLES)+1); no wrap-around permitted.

Reset
REQ-030 Reset asserted: state=IDLE, index=0, timer=0, note_code=0, note_valid=0, mem_rd_en=0, busy=0, play_done=0, immediately and without clock.
REQ-031 Reset asserted mid-playback abandons the song; after release the block waits for a new play_start.

Structure
REQ-032 Shared package composer_pkg holds NOTE_W, ADDR_W, REST code 8'h00 and the player state enum.
REQ-033 One sub-module duration_timer (loadable down-counter with zero flag) serves both PLAY and GAP.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2)
REQ-034 Memory {8'h1C,8'h1B,8'h23}, song_length=3, play_start at cycle 0 -> note_valid high cycles 3-6, 11-14, 19-22 with codes 1C,1B,23; play_done pulse cycle 25.
REQ-035 song_length=0, play_start -> no mem_rd_en, play_done one cycle after DONE entry, busy high one cycle.
REQ-036 Memory {8'h00,8'h1C}, length 2 -> note_valid low cycles 3-6, high 11-14 with 1C.
REQ-037 play_stop asserted at cycle 5 of REQ-034 run -> busy=0 and note_valid=0 from cycle 6, no play_done.
REQ-038 Second play_start at cycle 8 during playback -> ignored, sequence identical to REQ-034.
REQ-039 Reset asserted at cycle 12 mid-note -> all outputs 0 asynchronously; new play_start replays from index 0.
